// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for the execute stage.
// Signed and unsigned division, result {remainder, quotient} for the HI/LO write.
// Holds the pipeline with div_stall while the 32 iterations run.

`ifndef ALU_SIGNED_DIV
`define ALU_SIGNED_DIV   5'b10010
`endif
`ifndef ALU_UNSIGNED_DIV
`define ALU_UNSIGNED_DIV 5'b10011
`endif

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alu_controlE,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flushE,
    input  logic        stall_other,
    output logic        div_stall,
    output logic        div_ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q;
    logic [31:0] rem_q;      // partial remainder
    logic [31:0] dvd_q;      // dividend magnitude, shifted out MSB first
    logic [31:0] quo_q;      // quotient bits, shifted in LSB first
    logic [31:0] dvs_q;      // divisor magnitude
    logic        qs_q;       // negate quotient at the end
    logic        rs_q;       // negate remainder at the end
    logic [63:0] result_q;

    logic        is_div;
    logic        signed_op;
    logic        start;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic        last_iter;

    // Two's-complement negation, wrapping mod 2^32.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Unsigned magnitude of an operand; 0x80000000 maps to itself, which is
    // exactly its magnitude when read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? neg32(x) : x;
    endfunction

    assign is_div    = (alu_controlE == `ALU_SIGNED_DIV) || (alu_controlE == `ALU_UNSIGNED_DIV);
    assign signed_op = (alu_controlE == `ALU_SIGNED_DIV);
    assign start     = is_div && !flushE;

    // One restoring step: a negative trial (borrow in bit 32) restores.
    assign rem_shift = {rem_q, dvd_q[31]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign rem_next  = trial[32] ? rem_shift[31:0] : trial[31:0];
    assign quo_next  = {quo_q[30:0], ~trial[32]};
    assign last_iter = (count_q == 5'd31);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (b == 32'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall_other) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flushE) begin
            state_d = IDLE;
        end
    end

    // Operand capture at start, one iteration per BUSY cycle, result write on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 5'd0;
            rem_q    <= 32'd0;
            dvd_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            qs_q     <= 1'b0;
            rs_q     <= 1'b0;
            result_q <= 64'd0;
        end else if (!flushE) begin
            if (state_q == IDLE && is_div) begin
                if (b == 32'd0) begin
                    result_q <= 64'd0;
                end else begin
                    dvd_q   <= mag32(a, signed_op);
                    dvs_q   <= mag32(b, signed_op);
                    qs_q    <= signed_op && (a[31] ^ b[31]);
                    rs_q    <= signed_op && a[31];
                    rem_q   <= 32'd0;
                    quo_q   <= 32'd0;
                    count_q <= 5'd0;
                end
            end else if (state_q == BUSY) begin
                rem_q   <= rem_next;
                quo_q   <= quo_next;
                dvd_q   <= {dvd_q[30:0], 1'b0};
                count_q <= count_q + 5'd1;
                if (last_iter) begin
                    result_q <= {(rs_q ? neg32(rem_next) : rem_next),
                                 (qs_q ? neg32(quo_next) : quo_next)};
                end
            end
        end
    end

    // Stall is released in DONE so the instruction advances on the edge leaving it.
    assign div_stall = ((state_q == IDLE) && start) || (state_q == BUSY);
    assign div_ready = (state_q == DONE) && !flushE;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.

`timescale 1ns/1ps

`ifndef ALU_SIGNED_DIV
`define ALU_SIGNED_DIV   5'b10010
`endif
`ifndef ALU_UNSIGNED_DIV
`define ALU_UNSIGNED_DIV 5'b10011
`endif

module tb_div_unit;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_DIV  = `ALU_SIGNED_DIV;
    localparam logic [4:0] OP_DIVU = `ALU_UNSIGNED_DIV;

    logic        clk;
    logic        rst;
    logic [4:0]  alu_controlE;
    logic [31:0] a;
    logic [31:0] b;
    logic        flushE;
    logic        stall_other;
    logic        div_stall;
    logic        div_ready;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .alu_controlE (alu_controlE),
        .a            (a),
        .b            (b),
        .flushE       (flushE),
        .stall_other  (stall_other),
        .div_stall    (div_stall),
        .div_ready    (div_ready),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one division starting in the current cycle (call just after a rising edge)
    // and returns when the edge leaving DONE has passed. cycles = index of the first
    // ready cycle counted from the start cycle; stalls = cycles with div_stall high.
    task automatic run_div(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                           output int cycles, output int stalls, output bit got,
                           output logic [63:0] res);
        alu_controlE = op;
        a = av;
        b = bv;
        cycles = -1;
        stalls = 0;
        got = 1'b0;
        res = 64'd0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (div_ready) begin
                got = 1'b1;
                res = result;
                cycles = i;
                break;
            end
            if (div_stall) stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_controlE = OP_NOP; a = 32'd0; b = 32'd0; flushE = 1'b0; stall_other = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", div_ready); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL reset_stall_nop got=%b exp=0", div_stall); end
        alu_controlE = OP_DIVU; a = 32'd10; b = 32'd5; #1;
        total++; if (div_stall !== 1'b1) begin bad++; $display("FAIL idle_stall_div got=%b exp=1", div_stall); end
        flushE = 1'b1; #1;
        total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL idle_stall_flush got=%b exp=0", div_stall); end
        flushE = 1'b0; alu_controlE = OP_NOP;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int cyc, stl; bit got; logic [63:0] res;
        run_div(OP_DIVU, 32'd100, 32'd7, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (got !== 1'b1) begin bad++; $display("FAIL divu_100_7_ready got=%b exp=1", got); end
        total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7_result got=%h exp=%h", res, {32'd2, 32'd14}); end
        total++; if (stl !== 33) begin bad++; $display("FAIL divu_100_7_stall got=%0d exp=33", stl); end
        total++; if (cyc !== 33) begin bad++; $display("FAIL divu_100_7_latency got=%0d exp=33", cyc); end
    endtask

    task automatic test_flush();
        int cyc, stl; bit got; logic [63:0] res; bit seen;
        alu_controlE = OP_DIVU; a = 32'd100; b = 32'd7;
        repeat (11) @(posedge clk);
        #1 flushE = 1'b1; alu_controlE = OP_NOP;
        @(negedge clk);
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL flush_ready_now got=%b exp=0", div_ready); end
        @(posedge clk); #1 flushE = 1'b0;
        @(negedge clk);
        total++; if (div_stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", div_stall); end
        total++; if (result !== {32'd2, 32'd14}) begin bad++; $display("FAIL flush_result_held got=%h exp=%h", result, {32'd2, 32'd14}); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_ready) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_ready got=%b exp=0", seen); end
        @(posedge clk); #1;
        run_div(OP_DIVU, 32'd9, 32'd3, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== {32'd0, 32'd3} || got !== 1'b1) begin bad++; $display("FAIL flush_recover_result got=%h ready=%b exp=%h", res, got, {32'd0, 32'd3}); end
        total++; if (stl !== 33) begin bad++; $display("FAIL flush_recover_stall got=%0d exp=33", stl); end
    endtask

    task automatic test_signed();
        int cyc, stl; bit got; logic [63:0] res;
        run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || got !== 1'b1) begin bad++; $display("FAIL div_m7_2 got=%h exp=%h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
        run_div(OP_DIV, 32'd7, 32'hFFFFFFFE, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== {32'd1, 32'hFFFFFFFD} || got !== 1'b1) begin bad++; $display("FAIL div_7_m2 got=%h exp=%h", res, {32'd1, 32'hFFFFFFFD}); end
        run_div(OP_DIVU, 32'hFFFFFFFF, 32'd2, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== {32'd1, 32'h7FFFFFFF} || got !== 1'b1) begin bad++; $display("FAIL divu_max_2 got=%h exp=%h", res, {32'd1, 32'h7FFFFFFF}); end
    endtask

    task automatic test_overflow();
        int cyc, stl; bit got; logic [63:0] res;
        run_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (got !== 1'b1) begin bad++; $display("FAIL ovf_ready got=%b exp=1", got); end
        total++; if (res !== {32'd0, 32'h80000000}) begin bad++; $display("FAIL ovf_result got=%h exp=%h", res, {32'd0, 32'h80000000}); end
        total++; if (cyc !== 33) begin bad++; $display("FAIL ovf_latency got=%0d exp=33", cyc); end
    endtask

    task automatic test_div_zero();
        int cyc, stl; bit got; logic [63:0] res;
        run_div(OP_DIV, 32'd5, 32'd0, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== 64'd0 || got !== 1'b1) begin bad++; $display("FAIL div_by0_result got=%h ready=%b exp=0", res, got); end
        total++; if (cyc !== 1 || stl !== 1) begin bad++; $display("FAIL div_by0_timing latency=%0d stall=%0d exp=1/1", cyc, stl); end
        run_div(OP_DIVU, 32'd100, 32'd7, cyc, stl, got, res);
        run_div(OP_DIVU, 32'hFFFFFFFF, 32'd0, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== 64'd0 || got !== 1'b1) begin bad++; $display("FAIL divu_by0_result got=%h ready=%b exp=0", res, got); end
        total++; if (cyc !== 1 || stl !== 1) begin bad++; $display("FAIL divu_by0_timing latency=%0d stall=%0d exp=1/1", cyc, stl); end
    endtask

    task automatic test_reset_mid_busy();
        int cyc, stl; bit got; logic [63:0] res;
        alu_controlE = OP_DIVU; a = 32'd100; b = 32'd7;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1; alu_controlE = OP_NOP;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (div_ready !== 1'b0 || div_stall !== 1'b0) begin bad++; $display("FAIL rst_busy_idle ready=%b stall=%b exp=0/0", div_ready, div_stall); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL rst_busy_result got=%h exp=0", result); end
        @(posedge clk); #1;
        run_div(OP_DIVU, 32'd9, 32'd3, cyc, stl, got, res);
        alu_controlE = OP_NOP;
        total++; if (res !== {32'd0, 32'd3} || got !== 1'b1 || cyc !== 33) begin bad++; $display("FAIL rst_busy_recover got=%h latency=%0d exp=%h/33", res, cyc, {32'd0, 32'd3}); end
    endtask

    task automatic test_stall_other();
        bit got;
        stall_other = 1'b1;
        alu_controlE = OP_DIVU; a = 32'd100; b = 32'd7;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (div_ready) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (got !== 1'b1 || result !== {32'd2, 32'd14}) begin bad++; $display("FAIL hold_first ready=%b got=%h exp=%h", got, result, {32'd2, 32'd14}); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin stall_other = 1'b0; alu_controlE = OP_NOP; end
            @(negedge clk);
            total++; if (div_ready !== 1'b1 || result !== {32'd2, 32'd14} || div_stall !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d ready=%b stall=%b got=%h exp=1/0/%h", k, div_ready, div_stall, result, {32'd2, 32'd14});
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (div_ready !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", div_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_change();
        bit got; int cyc;
        alu_controlE = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 a = 32'd5; b = 32'd1; alu_controlE = OP_DIV;
        got = 1'b0; cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (div_ready) begin got = 1'b1; cyc = i; break; end
            @(posedge clk); #1;
        end
        alu_controlE = OP_NOP;
        total++; if (got !== 1'b1 || result !== {32'd2, 32'd14}) begin bad++; $display("FAIL opchg_result ready=%b got=%h exp=%h", got, result, {32'd2, 32'd14}); end
        total++; if (cyc !== 27) begin bad++; $display("FAIL opchg_latency got=%0d exp=27", cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc1, stl1, cyc2, stl2; bit got1, got2; logic [63:0] res1, res2;
        run_div(OP_DIVU, 32'd100, 32'd7, cyc1, stl1, got1, res1);
        run_div(OP_DIVU, 32'd9, 32'd3, cyc2, stl2, got2, res2);
        alu_controlE = OP_NOP;
        total++; if (res1 !== {32'd2, 32'd14} || got1 !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h exp=%h", res1, {32'd2, 32'd14}); end
        total++; if (res2 !== {32'd0, 32'd3} || got2 !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h exp=%h", res2, {32'd0, 32'd3}); end
        total++; if (cyc2 !== 33 || stl2 !== 33) begin bad++; $display("FAIL b2b_timing latency=%0d stall=%0d exp=33/33", cyc2, stl2); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_flush();
        test_signed();
        test_overflow();
        test_div_zero();
        test_reset_mid_busy();
        test_stall_other();
        test_operand_change();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
